// File: rtl/rv_fetch_pkg.sv
// Shared RV32IC fetch-side definitions: widths, the halfword type and the
// compressed-length test used by the align buffer.
package rv_fetch_pkg;

   localparam int          XLEN          = 32;
   localparam int          HW_W          = 16;
   localparam int          QUEUE_DEPTH   = 3;
   localparam logic [1:0]  RVC_QUAD_FULL = 2'b11;

   typedef logic [HW_W-1:0] halfword_t;
   typedef logic [1:0]      hw_count_t;

   // Any quadrant other than 11 marks a 16-bit instruction.
   function automatic logic is_rvc(input halfword_t hw);
      return hw[1:0] != RVC_QUAD_FULL;
   endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Fetch-word input, redirect and aligned-instruction output of the align buffer.
// master = surrounding fetch logic, slave = the align buffer itself.
interface fetch_align_buffer_if;
   import rv_fetch_pkg::*;

   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic [XLEN-1:0] fetch_addr;
   logic            in_valid;
   logic [XLEN-1:0] in_word;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            out_compressed;

   modport master (
      output flush, flush_pc, in_valid, in_word, out_ready,
      input  fetch_addr, in_ready, out_valid, out_instr, out_pc, out_compressed
   );

   modport slave (
      input  flush, flush_pc, in_valid, in_word, out_ready,
      output fetch_addr, in_ready, out_valid, out_instr, out_pc, out_compressed
   );

endinterface

// File: rtl/rvc_len_detect.sv
// Length decode of the oldest queued halfword: 1 = 16-bit (RVC) instruction.
module rvc_len_detect
   import rv_fetch_pkg::*;
(
   input  halfword_t hw,
   output logic      compressed
);

   assign compressed = is_rvc(hw);

endmodule

// File: rtl/fetch_align_buffer.sv
// Re-aligns word-aligned fetch data into whole RV32IC instructions on halfword
// boundaries, carrying the straddling halfword of a 32-bit instruction.
module fetch_align_buffer
   import rv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_align_buffer_if.slave  bus
);

   halfword_t       hw_q    [QUEUE_DEPTH];
   halfword_t       hw_next [QUEUE_DEPTH];
   hw_count_t       count_q;
   hw_count_t       count_next;
   logic [XLEN-1:0] fetch_addr_q;
   logic [XLEN-1:0] pc_q;
   logic            skip_hi_q;

   logic            compressed;
   logic            accept;
   logic            consume;
   hw_count_t       n_cons;
   hw_count_t       n_add;
   hw_count_t       remain;

   rvc_len_detect u_len (
      .hw         (hw_q[0]),
      .compressed (compressed)
   );

   assign bus.out_valid = !bus.flush && ((count_q >= 2'd1 && compressed) || count_q >= 2'd2);
   assign bus.in_ready  = !bus.flush && count_q <= 2'd1;
   assign accept        = bus.in_valid && bus.in_ready;
   assign consume       = bus.out_valid && bus.out_ready;

   // Gating on out_valid keeps the data outputs at zero while the queue is empty.
   assign bus.out_compressed = bus.out_valid && compressed;
   assign bus.out_instr      = !bus.out_valid ? '0
                             : compressed     ? {16'h0000, hw_q[0]}
                             :                  {hw_q[1], hw_q[0]};
   assign bus.out_pc         = pc_q;
   assign bus.fetch_addr     = fetch_addr_q;

   // Dequeue first, then append the new halfwords behind what remains.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      hw_next = hw_q;
      n_cons  = 2'd0;
      n_add   = 2'd0;
      if (consume) n_cons = compressed ? 2'd1 : 2'd2;
      remain = count_q - n_cons;

      case (n_cons)
         2'd1: begin
            hw_next[0] = hw_q[1];
            hw_next[1] = hw_q[2];
         end
         2'd2:    hw_next[0] = hw_q[2];
         default: ;
      endcase

      if (accept) begin
         if (skip_hi_q) begin
            hw_next[remain] = bus.in_word[31:16];
            n_add           = 2'd1;
         end else begin
            hw_next[remain]        = bus.in_word[15:0];
            hw_next[remain + 2'd1] = bus.in_word[31:16];
            n_add                  = 2'd2;
         end
      end

      count_next = remain + n_add;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         count_q      <= 2'd0;
         fetch_addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
         pc_q         <= {RESET_PC[XLEN-1:1], 1'b0};
         skip_hi_q    <= RESET_PC[1];
      end else if (bus.flush) begin
         count_q      <= 2'd0;
         fetch_addr_q <= {bus.flush_pc[XLEN-1:2], 2'b00};
         pc_q         <= {bus.flush_pc[XLEN-1:1], 1'b0};
         skip_hi_q    <= bus.flush_pc[1];
      end else begin
         count_q <= count_next;
         if (accept) begin
            fetch_addr_q <= fetch_addr_q + 32'd4;
            skip_hi_q    <= 1'b0;
         end
         if (consume) pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
      end
   end

   // NOTE: the halfword storage is not reset; count_q alone says which entries are live.
   always_ff @(posedge clk) begin
      hw_q <= hw_next;
   end

   // Bit 0 of a redirect target is meaningless for halfword-aligned PCs.
   logic unused_flush_pc0;
   assign unused_flush_pc0 = bus.flush_pc[0];

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: directed fetch words in, expected
// instructions queued, and a monitor checks every consumed instruction.
module tb_fetch_align_buffer;
   import rv_fetch_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_align_buffer_if bus();

   fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   exp_t  exp_q[$];
   word_t word_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] addr, input logic [31:0] word);
      word_t w;
      w.addr = addr;
      w.word = word;
      word_q.push_back(w);
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic c);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.c     = c;
      exp_q.push_back(e);
   endtask

   // Fetch-side driver: presents the head word and retires it when the handshake will complete.
   initial begin
      bus.in_valid = 1'b0;
      bus.in_word  = '0;
      forever begin
         @(negedge clk);
         if (!rst && word_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_word  = word_q[0].word;
            if (bus.in_ready) begin
               check("fetch_addr_at_accept", bus.fetch_addr, word_q[0].addr);
               void'(word_q.pop_front());
            end
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   end

   // Monitor: every instruction that is consumed must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_instr: got %h at pc %h, expected none", bus.out_instr, bus.out_pc);
            end else begin
               e = exp_q.pop_front();
               check("out_instr", bus.out_instr, e.instr);
               check("out_pc", bus.out_pc, e.pc);
               check("out_compressed", {31'b0, bus.out_compressed}, {31'b0, e.c});
            end
         end
      end
   end

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && (word_q.size() != 0 || exp_q.size() != 0); i++) @(posedge clk);
      if (word_q.size() != 0 || exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: got %0d words and %0d instrs pending, expected 0", name, word_q.size(), exp_q.size());
         word_q.delete();
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 50 && !bus.out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      check({name, "_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] target);
      @(posedge clk);
      #1;
      bus.flush    = 1'b1;
      bus.flush_pc = target;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush     = 1'b0;
      bus.flush_pc  = '0;
      bus.out_ready = 1'b1;

      // Reset state
      #3;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("rst_out_instr", bus.out_instr, 32'h0);
      check("rst_out_compressed", {31'b0, bus.out_compressed}, 32'd0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_fetch_addr", bus.fetch_addr, 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;

      // 1: two aligned 32-bit instructions
      push_word(32'h0, 32'h00A0_0093);
      push_word(32'h4, 32'h0010_0113);
      push_exp(32'h00A0_0093, 32'h0, 1'b0);
      push_exp(32'h0010_0113, 32'h4, 1'b0);
      wait_drain("t1");
      check("t1_fetch_addr_end", bus.fetch_addr, 32'h8);

      // 2: two compressed instructions from one word
      redirect(32'h0);
      push_word(32'h0, 32'h4505_4585);
      push_exp(32'h0000_4585, 32'h0, 1'b1);
      push_exp(32'h0000_4505, 32'h2, 1'b1);
      wait_drain("t2");
      check("t2_empty_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t2_empty_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("t2_out_pc_end", bus.out_pc, 32'h4);

      // 3: 32-bit instruction straddling a word boundary
      redirect(32'h0);
      push_word(32'h0, 32'h0093_4585);
      push_exp(32'h0000_4585, 32'h0, 1'b1);
      wait_drain("t3a");
      repeat (3) @(posedge clk);
      #1;
      check("t3_half_only_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t3_half_only_in_ready", {31'b0, bus.in_ready}, 32'd1);
      push_word(32'h4, 32'h1234_00A0);
      push_exp(32'h00A0_0093, 32'h2, 1'b0);
      push_exp(32'h0000_1234, 32'h6, 1'b1);
      wait_drain("t3b");

      // 4: flush while an instruction is valid, to a halfword-offset target
      redirect(32'h0);
      bus.out_ready = 1'b0;
      push_word(32'h0, 32'h00A0_0093);
      wait_valid("t4");
      bus.flush     = 1'b1;
      bus.flush_pc  = 32'h0000_0102;
      bus.out_ready = 1'b1;
      #1;
      check("t4_flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t4_flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("t4_fetch_addr", bus.fetch_addr, 32'h100);
      check("t4_out_pc", bus.out_pc, 32'h102);
      check("t4_out_valid_after", {31'b0, bus.out_valid}, 32'd0);
      push_word(32'h100, 32'h4505_ABCD);
      push_word(32'h104, 32'h00A0_0093);
      push_exp(32'h0000_4505, 32'h102, 1'b1);
      push_exp(32'h00A0_0093, 32'h104, 1'b0);
      wait_drain("t4");

      // 5: output stall with two halfwords queued
      redirect(32'h0);
      bus.out_ready = 1'b0;
      push_word(32'h0, 32'h00A0_0093);
      push_word(32'h4, 32'h4505_4585);
      push_exp(32'h00A0_0093, 32'h0, 1'b0);
      push_exp(32'h0000_4585, 32'h4, 1'b1);
      push_exp(32'h0000_4505, 32'h6, 1'b1);
      wait_valid("t5");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("t5_stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
         check("t5_stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
         check("t5_stall_out_instr", bus.out_instr, 32'h00A0_0093);
         check("t5_stall_out_pc", bus.out_pc, 32'h0);
      end
      bus.out_ready = 1'b1;
      wait_drain("t5");

      // 6: asynchronous reset in the middle of a straddled instruction
      redirect(32'h200);
      push_word(32'h200, 32'h0093_4585);
      push_exp(32'h0000_4585, 32'h200, 1'b1);
      wait_drain("t6a");
      bus.out_ready = 1'b0;
      push_word(32'h204, 32'h1234_00A0);
      wait_valid("t6");
      check("t6_pre_rst_out_pc", bus.out_pc, 32'h202);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("t6_rst_out_pc", bus.out_pc, 32'h0);
      check("t6_rst_fetch_addr", bus.fetch_addr, 32'h0);
      check("t6_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("t6_rst_out_instr", bus.out_instr, 32'h0);
      word_q.delete();
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      bus.out_ready = 1'b1;
      push_word(32'h0, 32'h4505_4585);
      push_exp(32'h0000_4585, 32'h0, 1'b1);
      push_exp(32'h0000_4505, 32'h2, 1'b1);
      wait_drain("t6b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
